// File: rtl/bool_trail_ctrl_if.sv
// bool_trail_ctrl_if: requester handshakes, status flags and bool-stack bus.
// master = requesters + stack side, slave = bool_trail_ctrl.
interface bool_trail_ctrl_if #(
  parameter int LVL_W = 7
);
  logic             dec_req;
  logic             conf_req;
  logic             dec_ack;
  logic             dec_err;
  logic [LVL_W-1:0] dec_level;
  logic             conf_ack;
  logic [LVL_W-1:0] bt_level;
  logic [LVL_W-1:0] bt_pops;
  logic             unsat;
  logic             err;
  logic             stk_push;
  logic             stk_din;
  logic             stk_pop;
  logic             stk_top;
  logic             stk_full;
  logic             stk_empty;

  modport master (
    output dec_req,
    output conf_req,
    output stk_top,
    output stk_full,
    output stk_empty,
    input  dec_ack,
    input  dec_err,
    input  dec_level,
    input  conf_ack,
    input  bt_level,
    input  bt_pops,
    input  unsat,
    input  err,
    input  stk_push,
    input  stk_din,
    input  stk_pop
  );

  modport slave (
    input  dec_req,
    input  conf_req,
    input  stk_top,
    input  stk_full,
    input  stk_empty,
    output dec_ack,
    output dec_err,
    output dec_level,
    output conf_ack,
    output bt_level,
    output bt_pops,
    output unsat,
    output err,
    output stk_push,
    output stk_din,
    output stk_pop
  );
endinterface

// File: rtl/bool_trail_ctrl.sv
// bool_trail_ctrl: sequences the DPLL decision bool stack (push on decide,
// pop exhausted levels + flip on conflict). Ports: clock, reset, bus (slave).
module bool_trail_ctrl #(
  parameter int STACK_DEPTH = 64,
  parameter int LVL_W       = 7
) (
  input  logic             clock,
  input  logic             reset,
  bool_trail_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_D_PUSH,
    S_D_WAIT,
    S_D_ACK,
    S_C_CHECK,
    S_C_POP,
    S_C_WAIT,
    S_F_POP,
    S_F_WAIT1,
    S_F_PUSH,
    S_F_WAIT2,
    S_C_ACK,
    S_UNSAT,
    S_ERR
  } state_t;

  localparam logic [LVL_W-1:0] LP_CAP = LVL_W'(STACK_DEPTH);
  localparam logic [LVL_W-1:0] LP_ONE = LVL_W'(1);

  state_t           r_state;
  state_t           w_state_n;
  logic [LVL_W-1:0] r_depth;
  logic [LVL_W-1:0] w_depth_n;
  logic [LVL_W-1:0] r_pops;
  logic [LVL_W-1:0] w_pops_n;

  logic             r_dec_ack;
  logic             r_dec_err;
  logic [LVL_W-1:0] r_dec_level;
  logic             r_conf_ack;
  logic [LVL_W-1:0] r_bt_level;
  logic [LVL_W-1:0] r_bt_pops;
  logic             r_unsat;
  logic             r_err;
  logic             r_stk_push;
  logic             r_stk_din;
  logic             r_stk_pop;

  logic             w_dec_ack;
  logic             w_dec_err;
  logic [LVL_W-1:0] w_dec_level;
  logic             w_conf_ack;
  logic [LVL_W-1:0] w_bt_level;
  logic [LVL_W-1:0] w_bt_pops;
  logic             w_unsat;
  logic             w_err;
  logic             w_stk_push;
  logic             w_stk_din;
  logic             w_stk_pop;

  logic             w_at_cap;

  assign w_at_cap = (r_depth == LP_CAP) || bus.stk_full;

  // Outputs are computed for the state being entered and registered
  // with it, so each pulse lines up with its state's cycle.
  always_comb begin
    w_state_n   = r_state;
    w_depth_n   = r_depth;
    w_pops_n    = r_pops;
    w_dec_ack   = 1'b0;
    w_dec_err   = 1'b0;
    w_dec_level = '0;
    w_conf_ack  = 1'b0;
    w_bt_level  = '0;
    w_bt_pops   = '0;
    w_unsat     = r_unsat;
    w_err       = r_err;
    w_stk_push  = 1'b0;
    w_stk_din   = 1'b0;
    w_stk_pop   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (bus.conf_req) begin
          w_pops_n  = '0;
          w_state_n = S_C_CHECK;
        end else if (bus.dec_req) begin
          if (w_at_cap) begin
            w_state_n   = S_D_ACK;
            w_dec_ack   = 1'b1;
            w_dec_err   = 1'b1;
            w_dec_level = r_depth;
          end else begin
            w_state_n  = S_D_PUSH;
            w_stk_push = 1'b1;
            w_depth_n  = r_depth + LP_ONE;
          end
        end
      end

      S_D_PUSH: begin
        w_state_n = S_D_WAIT;
      end

      S_D_WAIT: begin
        w_state_n   = S_D_ACK;
        w_dec_ack   = 1'b1;
        w_dec_level = r_depth;
      end

      S_D_ACK: begin
        w_state_n = S_IDLE;
      end

      // Depth is checked before the flags: an empty trail is UNSAT,
      // while a non-zero depth over an empty stack is a sync fault.
      S_C_CHECK: begin
        if (r_depth == '0) begin
          w_state_n  = S_UNSAT;
          w_unsat    = 1'b1;
          w_conf_ack = 1'b1;
          w_bt_pops  = r_pops;
        end else if (bus.stk_empty) begin
          w_state_n = S_ERR;
          w_err     = 1'b1;
        end else if (bus.stk_top) begin
          w_state_n = S_C_POP;
          w_stk_pop = 1'b1;
          w_depth_n = r_depth - LP_ONE;
          w_pops_n  = r_pops + LP_ONE;
        end else begin
          w_state_n = S_F_POP;
          w_stk_pop = 1'b1;
        end
      end

      S_C_POP: begin
        w_state_n = S_C_WAIT;
      end

      S_C_WAIT: begin
        w_state_n = S_C_CHECK;
      end

      S_F_POP: begin
        w_state_n = S_F_WAIT1;
      end

      // Flip: the popped 0 comes back as 1 (both polarities tried).
      S_F_WAIT1: begin
        w_state_n  = S_F_PUSH;
        w_stk_push = 1'b1;
        w_stk_din  = 1'b1;
      end

      S_F_PUSH: begin
        w_state_n = S_F_WAIT2;
      end

      S_F_WAIT2: begin
        w_state_n  = S_C_ACK;
        w_conf_ack = 1'b1;
        w_bt_level = r_depth;
        w_bt_pops  = r_pops;
      end

      S_C_ACK: begin
        w_state_n = S_IDLE;
      end

      S_UNSAT: begin
        w_state_n = S_UNSAT;
      end

      S_ERR: begin
        w_state_n = S_ERR;
      end

      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_depth     <= '0;
      r_pops      <= '0;
      r_dec_ack   <= 1'b0;
      r_dec_err   <= 1'b0;
      r_dec_level <= '0;
      r_conf_ack  <= 1'b0;
      r_bt_level  <= '0;
      r_bt_pops   <= '0;
      r_unsat     <= 1'b0;
      r_err       <= 1'b0;
      r_stk_push  <= 1'b0;
      r_stk_din   <= 1'b0;
      r_stk_pop   <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_depth     <= w_depth_n;
      r_pops      <= w_pops_n;
      r_dec_ack   <= w_dec_ack;
      r_dec_err   <= w_dec_err;
      r_dec_level <= w_dec_level;
      r_conf_ack  <= w_conf_ack;
      r_bt_level  <= w_bt_level;
      r_bt_pops   <= w_bt_pops;
      r_unsat     <= w_unsat;
      r_err       <= w_err;
      r_stk_push  <= w_stk_push;
      r_stk_din   <= w_stk_din;
      r_stk_pop   <= w_stk_pop;
    end
  end

  assign bus.dec_ack   = r_dec_ack;
  assign bus.dec_err   = r_dec_err;
  assign bus.dec_level = r_dec_level;
  assign bus.conf_ack  = r_conf_ack;
  assign bus.bt_level  = r_bt_level;
  assign bus.bt_pops   = r_bt_pops;
  assign bus.unsat     = r_unsat;
  assign bus.err       = r_err;
  assign bus.stk_push  = r_stk_push;
  assign bus.stk_din   = r_stk_din;
  assign bus.stk_pop   = r_stk_pop;

endmodule

// File: tb/tb_bool_trail_ctrl.sv
// tb_bool_trail_ctrl: bool_trail_ctrl with a 4-deep stack model,
// directed scenarios plus randomized requests against a schedule model.
module tb_bool_trail_ctrl;

  localparam int DEPTH = 4;
  localparam int LW    = 7;
  localparam int BIG   = 1 << 30;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  bool_trail_ctrl_if #(.LVL_W(LW)) bus();

  bool_trail_ctrl #(
    .STACK_DEPTH(DEPTH),
    .LVL_W(LW)
  ) u_dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask

  // ---------------- stack model: flags lag an op by two cycles
  bit mem[DEPTH];
  int sc      = 0;
  int n_ops   = 0;
  bit top_r   = 1'b0;
  bit full_r  = 1'b0;
  bit empty_r = 1'b1;
  bit wiped   = 1'b0;
  bit wipe_req;

  assign bus.stk_top   = top_r;
  assign bus.stk_full  = full_r;
  assign bus.stk_empty = empty_r;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      sc      <= 0;
      top_r   <= 1'b0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      wiped   <= 1'b0;
    end else begin
      if (bus.stk_push || bus.stk_pop) n_ops <= n_ops + 1;
      if (wipe_req) begin
        sc    <= 0;
        wiped <= 1'b1;
      end else if (bus.stk_push && sc < DEPTH) begin
        mem[sc] <= bus.stk_din;
        sc      <= sc + 1;
      end else if (bus.stk_pop && sc > 0) begin
        sc <= sc - 1;
      end
      top_r   <= (sc > 0) ? mem[sc-1] : 1'b0;
      full_r  <= (sc == DEPTH);
      empty_r <= (sc == 0);
    end
  end

  // ---------------- schedule model: expected events per cycle
  typedef struct packed {
    bit push; bit din; bit pop; bit dack; bit derr; bit cack;
    int dlvl; int btl; int btp;
  } ev_t;

  ev_t sched[int];
  bit  trail[$];
  int  free_at  = 0;
  int  unsat_at = -1;
  int  err_at   = -1;
  int  m_fw1    = -1;
  int  n_cack   = 0;

  function automatic ev_t ev_get(input int c);
    ev_t e;
    e = '0;
    if (sched.exists(c)) e = sched[c];
    return e;
  endfunction

  function automatic void s_push(input int c, input bit d);
    ev_t e = ev_get(c);
    e.push = 1'b1; e.din = d; sched[c] = e;
  endfunction

  function automatic void s_pop(input int c);
    ev_t e = ev_get(c);
    e.pop = 1'b1; sched[c] = e;
  endfunction

  function automatic void s_dack(input int c, input bit er, input int l);
    ev_t e = ev_get(c);
    e.dack = 1'b1; e.derr = er; e.dlvl = l; sched[c] = e;
  endfunction

  function automatic void s_cack(input int c, input int l, input int p);
    ev_t e = ev_get(c);
    e.cack = 1'b1; e.btl = l; e.btp = p; sched[c] = e;
  endfunction

  ev_t ce;
  int  b;
  int  k;

  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        sched.delete();
        trail.delete();
        free_at  = 0;
        unsat_at = -1;
        err_at   = -1;
      end
      ce = ev_get(cyc);
      chk("stk_push", bus.stk_push, ce.push);
      chk("stk_pop",  bus.stk_pop,  ce.pop);
      chk("dec_ack",  bus.dec_ack,  ce.dack);
      chk("conf_ack", bus.conf_ack, ce.cack);
      chk("unsat", bus.unsat, int'(unsat_at >= 0 && cyc >= unsat_at));
      chk("err",   bus.err,   int'(err_at >= 0 && cyc >= err_at));
      if (ce.push) chk("stk_din", bus.stk_din, ce.din);
      if (ce.dack) begin
        chk("dec_err",   bus.dec_err,   ce.derr);
        chk("dec_level", bus.dec_level, ce.dlvl);
      end
      if (ce.cack) begin
        chk("bt_level", bus.bt_level, ce.btl);
        chk("bt_pops",  bus.bt_pops,  ce.btp);
      end
      if (bus.conf_ack) n_cack++;
      sched.delete(cyc);

      if (!reset && cyc >= free_at) begin
        b = cyc;
        k = 0;
        if (bus.conf_req) begin
          if (wiped && trail.size() > 0) begin
            err_at  = b + 2;
            free_at = BIG;
          end else begin
            while (trail.size() > 0 && trail[trail.size()-1]) begin
              void'(trail.pop_back());
              s_pop(b + 2 + 3*k);
              k++;
            end
            if (trail.size() == 0) begin
              s_cack(b + 2 + 3*k, 0, k);
              unsat_at = b + 2 + 3*k;
              free_at  = BIG;
            end else begin
              s_pop(b + 2 + 3*k);
              m_fw1 = b + 3 + 3*k;
              s_push(b + 4 + 3*k, 1'b1);
              trail[trail.size()-1] = 1'b1;
              s_cack(b + 6 + 3*k, trail.size(), k);
              free_at = b + 7 + 3*k;
            end
          end
        end else if (bus.dec_req) begin
          if (trail.size() == DEPTH) begin
            s_dack(b + 1, 1'b1, DEPTH);
            free_at = b + 2;
          end else begin
            s_push(b + 1, 1'b0);
            trail.push_back(1'b0);
            s_dack(b + 3, 1'b0, trail.size());
            free_at = b + 4;
          end
        end
      end
    end
  end

  // ---------------- driver
  int cap_dlvl, cap_derr, cap_btl, cap_btp;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    bus.dec_req  = 1'b0;
    bus.conf_req = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic do_req(input bit conf, input int maxw,
                        output bit got, output int lat);
    int t;
    tick();
    t   = cyc;
    got = 1'b0;
    lat = -1;
    if (conf) bus.conf_req = 1'b1;
    else      bus.dec_req  = 1'b1;
    for (int n = 0; n < maxw; n++) begin
      tick();
      if ((conf && bus.conf_ack) || (!conf && bus.dec_ack)) begin
        got      = 1'b1;
        lat      = cyc - t;
        cap_dlvl = bus.dec_level;
        cap_derr = bus.dec_err;
        cap_btl  = bus.bt_level;
        cap_btp  = bus.bt_pops;
        break;
      end
    end
    bus.conf_req = 1'b0;
    bus.dec_req  = 1'b0;
  endtask

  function automatic int all_outs();
    return int'({bus.dec_ack, bus.dec_err, bus.dec_level,
                 bus.conf_ack, bus.bt_level, bus.bt_pops,
                 bus.unsat, bus.err,
                 bus.stk_push, bus.stk_din, bus.stk_pop});
  endfunction

  bit got;
  int lat, ops0, cack0, t0, dc, cc, dl, dwait, cwait;
  bit found;

  initial begin
    bus.dec_req  = 1'b0;
    bus.conf_req = 1'b0;
    wipe_req     = 1'b0;
    reset        = 1'b1;
    tick();
    tick();
    chk("reset_outs", all_outs(), 0);
    reset = 1'b0;

    // three decisions: levels 1..3, latency 3
    for (int i = 1; i <= 3; i++) begin
      do_req(1'b0, 40, got, lat);
      chk("dec_got", got, 1);
      chk("dec_lat", lat, 3);
      chk("dec_lvl", cap_dlvl, i);
      chk("dec_err0", cap_derr, 0);
    end
    chk("stk_cnt3", sc, 3);
    chk("stk_000", int'({mem[0], mem[1], mem[2]}), 0);

    // flip of the top 0: two ops, latency 6
    ops0 = n_ops;
    do_req(1'b1, 40, got, lat);
    chk("flip_lat", lat, 6);
    chk("flip_btl", cap_btl, 3);
    chk("flip_btp", cap_btp, 0);
    chk("flip_ops", n_ops - ops0, 2);
    chk("flip_top", bus.stk_top, 1);

    // trail 0,1,1 -> two pops then flip, latency 12
    apply_reset();
    do_req(1'b0, 40, got, lat);
    do_req(1'b0, 40, got, lat);
    do_req(1'b1, 40, got, lat);
    do_req(1'b0, 40, got, lat);
    do_req(1'b1, 40, got, lat);
    do_req(1'b1, 40, got, lat);
    chk("bt2_lat", lat, 12);
    chk("bt2_btl", cap_btl, 1);
    chk("bt2_btp", cap_btp, 2);
    chk("bt2_cnt", sc, 1);
    chk("bt2_bit", mem[0], 1);

    // trail 1,1 -> unsat after two pops
    do_req(1'b0, 40, got, lat);
    do_req(1'b1, 40, got, lat);
    do_req(1'b1, 40, got, lat);
    chk("uns_got", got, 1);
    chk("uns_lat", lat, 8);
    chk("uns_btl", cap_btl, 0);
    chk("uns_btp", cap_btp, 2);
    chk("uns_flag", bus.unsat, 1);
    do_req(1'b0, 20, got, lat);
    chk("uns_noack", got, 0);
    apply_reset();
    chk("uns_clr", bus.unsat, 0);

    // simultaneous requests: conflict first
    do_req(1'b0, 40, got, lat);
    tick();
    t0 = cyc;
    dc = -1;
    cc = -1;
    dl = -1;
    bus.dec_req  = 1'b1;
    bus.conf_req = 1'b1;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (bus.conf_ack && cc < 0) begin
        cc = cyc - t0;
        bus.conf_req = 1'b0;
      end
      if (bus.dec_ack && dc < 0) begin
        dc = cyc - t0;
        dl = bus.dec_level;
        bus.dec_req = 1'b0;
      end
      if (dc >= 0 && cc >= 0) break;
    end
    bus.dec_req  = 1'b0;
    bus.conf_req = 1'b0;
    chk("arb_conf_lat", cc, 6);
    chk("arb_dec_lat", dc, 10);
    chk("arb_dec_lvl", dl, 2);

    // fill to capacity, fifth decide errors without a push
    apply_reset();
    for (int i = 1; i <= 4; i++) begin
      do_req(1'b0, 40, got, lat);
      chk("fill_lvl", cap_dlvl, i);
    end
    ops0 = n_ops;
    do_req(1'b0, 40, got, lat);
    chk("full_got", got, 1);
    chk("full_lat", lat, 1);
    chk("full_err", cap_derr, 1);
    chk("full_lvl", cap_dlvl, 4);
    chk("full_ops", n_ops - ops0, 0);

    // reset during F_WAIT1
    tick();
    bus.conf_req = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (cyc == m_fw1) begin
        found = 1'b1;
        break;
      end
    end
    chk("fw1_found", found, 1);
    chk("fw1_popped", sc, 3);
    cack0 = n_cack;
    reset = 1'b1;
    bus.conf_req = 1'b0;
    #1;
    chk("fw1_rst_outs", all_outs(), 0);
    tick();
    tick();
    reset = 1'b0;
    repeat (10) tick();
    chk("fw1_noack", n_cack - cack0, 0);
    chk("fw1_stk0", sc, 0);
    do_req(1'b0, 40, got, lat);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_lvl", cap_dlvl, 1);

    // depth/stack disagreement -> sticky err, no ack
    apply_reset();
    do_req(1'b0, 40, got, lat);
    do_req(1'b0, 40, got, lat);
    wipe_req = 1'b1;
    tick();
    wipe_req = 1'b0;
    repeat (3) tick();
    do_req(1'b1, 12, got, lat);
    chk("err_noack", got, 0);
    chk("err_flag", bus.err, 1);
    chk("err_nounsat", bus.unsat, 0);
    apply_reset();
    chk("err_clr", bus.err, 0);

    // randomized requests
    for (int r = 0; r < 10; r++) begin
      apply_reset();
      dwait = 0;
      cwait = 0;
      for (int n = 0; n < 150; n++) begin
        tick();
        if (unsat_at >= 0 || err_at >= 0) break;
        if (bus.dec_req && bus.dec_ack) begin
          bus.dec_req = 1'b0;
          dwait = 0;
        end else if (bus.dec_req) begin
          dwait++;
          if (dwait > 60) begin
            chk("rnd_dec_timeout", dwait, 0);
            bus.dec_req = 1'b0;
            dwait = 0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          bus.dec_req = 1'b1;
        end
        if (bus.conf_req && bus.conf_ack) begin
          bus.conf_req = 1'b0;
          cwait = 0;
        end else if (bus.conf_req) begin
          cwait++;
          if (cwait > 60) begin
            chk("rnd_conf_timeout", cwait, 0);
            bus.conf_req = 1'b0;
            cwait = 0;
          end
        end else if ($urandom_range(0, 5) == 0) begin
          bus.conf_req = 1'b1;
        end
      end
    end
    apply_reset();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
